mux_nch_scan: RTL and testbench

//   Parametrised N-channel, WIDTH-bit registered multiplexer. Successor to the fixed 8:1 combinational mux.

---
 rtl/mux_nch_scan.sv | 128 ++++++++++++
 tb/tb_mux_nch_scan.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nch_scan.sv
// mux_nch_scan: N-channel registered multiplexer with manual select and
// round-robin scan modes. One clock of latency from select/data to output.
module mux_nch_scan #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3,
    parameter int DWELL  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel_in,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    scan_wrap,
    output logic                    sel_err
);

    localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W-1:0] ONE_SEL  = SEL_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    // Select width must cover the channels exactly; a mismatch is a config bug.
    if (SEL_W != $clog2(NUM_CH)) begin : g_bad_sel_w
        $error("mux_nch_scan: SEL_W must equal $clog2(NUM_CH)");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MANUAL = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              wrap_q, wrap_d;
    logic              err_q, err_d;

    // Channels unpacked into a full 2**SEL_W table so any select value is a
    // legal index; unused slots (non-power-of-2 NUM_CH) read as zero.
    logic [WIDTH-1:0] ch_data [2**SEL_W];

    for (genvar k = 0; k < 2**SEL_W; k++) begin : g_ch
        if (k < NUM_CH) begin : g_used
            assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign ch_data[k] = '0;
        end
    end

    // Next-state, select, dwell and output-register decode.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (en) begin
            valid_d = 1'b1;
            if (!mode) begin
                // Manual: out-of-range selects keep the current channel.
                state_d = S_MANUAL;
                cnt_d   = '0;
                if ({1'b0, sel_in} < NUM_CH_W) begin
                    sel_d = sel_in;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                state_d = S_SCAN;
                if (state_q != S_SCAN) begin
                    // Entering scan: full dwell on the channel already selected.
                    cnt_d = '0;
                end else if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (sel_q == LAST_CH) begin
                        sel_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        sel_d = sel_q + ONE_SEL;
                    end
                end else begin
                    cnt_d = cnt_q + ONE_CNT;
                end
            end
            data_d = ch_data[sel_d];
        end
    end

    // State and output registers; en=0 holds everything but drops the flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign cur_sel   = sel_q;
    assign scan_wrap = wrap_q;
    assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_nch_scan.sv
// tb_mux_nch_scan: drives an 8-channel and a 5-channel instance from shared
// stimulus and compares both against a cycle-level behavioural model.
module tb_mux_nch_scan;

    localparam int DW = 4;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [2:0]  sel_in;
    logic [63:0] in8;

    logic [7:0] o8_data, o5_data;
    logic       o8_valid, o5_valid;
    logic [2:0] o8_sel, o5_sel;
    logic       o8_wrap, o5_wrap;
    logic       o8_err, o5_err;

    int checks;
    int failures;

    // Behavioural model: index 0 = 8-channel DUT, index 1 = 5-channel DUT.
    int         NCH [2] = '{8, 5};
    bit         m_scan [2];
    int         m_held [2];
    int         m_sel  [2];
    logic [7:0] m_data [2];
    bit         m_valid[2];
    bit         m_wrap [2];
    bit         m_err  [2];

    mux_nch_scan #(.WIDTH(8), .NUM_CH(8), .SEL_W(3), .DWELL(DW)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_data(in8), .en(en), .mode(mode),
        .sel_in(sel_in), .out_data(o8_data), .out_valid(o8_valid),
        .cur_sel(o8_sel), .scan_wrap(o8_wrap), .sel_err(o8_err)
    );

    mux_nch_scan #(.WIDTH(8), .NUM_CH(5), .SEL_W(3), .DWELL(DW)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_data(in8[39:0]), .en(en), .mode(mode),
        .sel_in(sel_in), .out_data(o5_data), .out_valid(o5_valid),
        .cur_sel(o5_sel), .scan_wrap(o5_wrap), .sel_err(o5_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_scan[i] = 0; m_held[i] = 0; m_sel[i] = 0; m_data[i] = '0;
            m_valid[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
        end
    endtask

    // One enabled/disabled clock as seen from the outside: m_held is the
    // number of cycles the current channel has been presented while scanning.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_wrap[i] = 0;
            m_err[i]  = 0;
            if (!en) begin
                m_valid[i] = 0;
            end else begin
                m_valid[i] = 1;
                if (!mode) begin
                    m_scan[i] = 0;
                    m_held[i] = 0;
                    if (int'(sel_in) < NCH[i]) m_sel[i] = int'(sel_in);
                    else m_err[i] = 1;
                end else if (!m_scan[i]) begin
                    m_scan[i] = 1;
                    m_held[i] = 1;
                end else if (m_held[i] == DW) begin
                    m_sel[i]  = (m_sel[i] + 1) % NCH[i];
                    m_wrap[i] = (m_sel[i] == 0);
                    m_held[i] = 1;
                end else begin
                    m_held[i]++;
                end
                m_data[i] = in8[m_sel[i]*8 +: 8];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_in = '0; in8 = '0;
        model_reset();
        #2;
        checks++;
        if ({o8_data, o8_valid, o8_sel, o8_wrap, o8_err} !== 14'd0) begin
            failures++;
            $display("FAIL reset_dut8 got=%h exp=0", {o8_data, o8_valid, o8_sel, o8_wrap, o8_err});
        end
        checks++;
        if ({o5_data, o5_valid, o5_sel, o5_wrap, o5_err} !== 14'd0) begin
            failures++;
            $display("FAIL reset_dut5 got=%h exp=0", {o5_data, o5_valid, o5_sel, o5_wrap, o5_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_manual_sweep();
        for (int k = 0; k < 8; k++) in8[k*8 +: 8] = 8'(k*16 + 1);
        en = 1'b1; mode = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sel_in = 3'(s);
            tick();
            checks++;
            if (o8_data !== 8'(s*16 + 1) || o8_sel !== 3'(s) || o8_valid !== 1'b1) begin
                failures++;
                $display("FAIL sweep_sel%0d got data=%h sel=%0d valid=%b exp data=%h sel=%0d valid=1",
                         s, o8_data, o8_sel, o8_valid, 8'(s*16 + 1), s);
            end
            checks++;
            if ({o5_data, o5_valid, o5_sel, o5_wrap, o5_err} !==
                {m_data[1], m_valid[1], 3'(m_sel[1]), m_wrap[1], m_err[1]}) begin
                failures++;
                $display("FAIL sweep_dut5 s=%0d got=%h exp=%h", s,
                         {o5_data, o5_valid, o5_sel, o5_wrap, o5_err},
                         {m_data[1], m_valid[1], 3'(m_sel[1]), m_wrap[1], m_err[1]});
            end
        end
    endtask

    task automatic test_scan();
        int bad;
        int wraps;
        do_reset();
        en = 1'b1; mode = 1'b1; bad = 0; wraps = 0;
        for (int c = 0; c < 40; c++) begin
            in8 = {$urandom, $urandom};
            tick();
            if (o8_wrap) wraps++;
            if (o8_sel !== 3'((c / DW) % 8) || o8_wrap !== (c == 32)) bad++;
            checks++;
            if ({o8_data, o8_valid, o8_sel, o8_wrap, o8_err} !==
                {m_data[0], m_valid[0], 3'(m_sel[0]), m_wrap[0], m_err[0]}) begin
                failures++;
                $display("FAIL scan_dut8 c=%0d got=%h exp=%h", c,
                         {o8_data, o8_valid, o8_sel, o8_wrap, o8_err},
                         {m_data[0], m_valid[0], 3'(m_sel[0]), m_wrap[0], m_err[0]});
            end
            checks++;
            if ({o5_data, o5_valid, o5_sel, o5_wrap, o5_err} !==
                {m_data[1], m_valid[1], 3'(m_sel[1]), m_wrap[1], m_err[1]}) begin
                failures++;
                $display("FAIL scan_dut5 c=%0d got=%h exp=%h", c,
                         {o5_data, o5_valid, o5_sel, o5_wrap, o5_err},
                         {m_data[1], m_valid[1], 3'(m_sel[1]), m_wrap[1], m_err[1]});
            end
        end
        checks++;
        if (bad != 0 || wraps != 1) begin
            failures++;
            $display("FAIL scan_dwell_wrap got bad_cycles=%0d wraps=%0d exp 0 and 1", bad, wraps);
        end
    endtask

    task automatic test_en_pause();
        int exp_sel [3] = '{1, 1, 2};
        do_reset();
        en = 1'b1; mode = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        // Mid-dwell on channel 1; toggle mode while paused to show en wins.
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mode = (c == 1) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (o8_valid !== 1'b0 || o8_sel !== 3'd1 || o8_wrap !== 1'b0 || o8_err !== 1'b0) begin
                failures++;
                $display("FAIL pause_hold c=%0d got valid=%b sel=%0d wrap=%b err=%b exp 0,1,0,0",
                         c, o8_valid, o8_sel, o8_wrap, o8_err);
            end
        end
        en = 1'b1; mode = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (o8_sel !== 3'(exp_sel[c]) || o8_valid !== 1'b1) begin
                failures++;
                $display("FAIL pause_resume c=%0d got sel=%0d valid=%b exp sel=%0d valid=1",
                         c, o8_sel, o8_valid, exp_sel[c]);
            end
            checks++;
            if ({o5_data, o5_valid, o5_sel, o5_wrap, o5_err} !==
                {m_data[1], m_valid[1], 3'(m_sel[1]), m_wrap[1], m_err[1]}) begin
                failures++;
                $display("FAIL pause_dut5 c=%0d got=%h exp=%h", c,
                         {o5_data, o5_valid, o5_sel, o5_wrap, o5_err},
                         {m_data[1], m_valid[1], 3'(m_sel[1]), m_wrap[1], m_err[1]});
            end
        end
    endtask

    task automatic test_sel_err();
        logic [2:0] before_sel;
        logic [7:0] before_data;
        en = 1'b1; mode = 1'b0; sel_in = 3'd2;
        in8 = {$urandom, $urandom};
        tick();
        before_sel  = o5_sel;
        before_data = o5_data;
        sel_in = 3'd6;
        tick();
        checks++;
        if (o5_err !== 1'b1 || o5_sel !== before_sel || o5_data !== before_data || o5_valid !== 1'b1) begin
            failures++;
            $display("FAIL sel_err_dut5 got err=%b sel=%0d data=%h valid=%b exp 1,%0d,%h,1",
                     o5_err, o5_sel, o5_data, o5_valid, before_sel, before_data);
        end
        checks++;
        if (o8_err !== 1'b0 || o8_sel !== 3'd6) begin
            failures++;
            $display("FAIL sel_err_dut8 got err=%b sel=%0d exp err=0 sel=6", o8_err, o8_sel);
        end
        sel_in = 3'd1;
        tick();
        checks++;
        if (o5_err !== 1'b0 || o5_sel !== 3'd1) begin
            failures++;
            $display("FAIL sel_err_pulse got err=%b sel=%0d exp err=0 sel=1", o5_err, o5_sel);
        end
        for (int c = 0; c < 30; c++) begin
            sel_in = 3'($urandom_range(0, 7));
            in8 = {$urandom, $urandom};
            tick();
            checks++;
            if ({o5_data, o5_valid, o5_sel, o5_wrap, o5_err} !==
                {m_data[1], m_valid[1], 3'(m_sel[1]), m_wrap[1], m_err[1]}) begin
                failures++;
                $display("FAIL sel_err_rand c=%0d got=%h exp=%h", c,
                         {o5_data, o5_valid, o5_sel, o5_wrap, o5_err},
                         {m_data[1], m_valid[1], 3'(m_sel[1]), m_wrap[1], m_err[1]});
            end
        end
    endtask

    task automatic test_mode_toggle();
        do_reset();
        en = 1'b1; mode = 1'b1;
        for (int c = 0; c < 15; c++) tick();
        checks++;
        if (o8_sel !== 3'd3) begin
            failures++;
            $display("FAIL toggle_pre got sel=%0d exp sel=3", o8_sel);
        end
        mode = 1'b0; sel_in = 3'd6;
        tick();
        checks++;
        if (o8_sel !== 3'd6 || o8_valid !== 1'b1) begin
            failures++;
            $display("FAIL toggle_manual got sel=%0d valid=%b exp sel=6 valid=1", o8_sel, o8_valid);
        end
        mode = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (o8_sel !== ((c < 4) ? 3'd6 : 3'd7)) begin
                failures++;
                $display("FAIL toggle_rescan c=%0d got sel=%0d exp sel=%0d", c, o8_sel, (c < 4) ? 6 : 7);
            end
            checks++;
            if ({o5_data, o5_valid, o5_sel, o5_wrap, o5_err} !==
                {m_data[1], m_valid[1], 3'(m_sel[1]), m_wrap[1], m_err[1]}) begin
                failures++;
                $display("FAIL toggle_dut5 c=%0d got=%h exp=%h", c,
                         {o5_data, o5_valid, o5_sel, o5_wrap, o5_err},
                         {m_data[1], m_valid[1], 3'(m_sel[1]), m_wrap[1], m_err[1]});
            end
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; mode = 1'b1;
        in8 = {$urandom, $urandom};
        for (int c = 0; c < 7; c++) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({o8_data, o8_valid, o8_sel, o8_wrap, o8_err} !== 14'd0 ||
            {o5_data, o5_valid, o5_sel, o5_wrap, o5_err} !== 14'd0) begin
            failures++;
            $display("FAIL async_reset got dut8=%h dut5=%h exp 0",
                     {o8_data, o8_valid, o8_sel, o8_wrap, o8_err},
                     {o5_data, o5_valid, o5_sel, o5_wrap, o5_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            en = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            sel_in = 3'($urandom_range(0, 7));
            in8 = {$urandom, $urandom};
            tick();
            checks++;
            if ({o8_data, o8_valid, o8_sel, o8_wrap, o8_err} !==
                {m_data[0], m_valid[0], 3'(m_sel[0]), m_wrap[0], m_err[0]}) begin
                failures++;
                $display("FAIL random_dut8 c=%0d got=%h exp=%h", c,
                         {o8_data, o8_valid, o8_sel, o8_wrap, o8_err},
                         {m_data[0], m_valid[0], 3'(m_sel[0]), m_wrap[0], m_err[0]});
            end
            checks++;
            if ({o5_data, o5_valid, o5_sel, o5_wrap, o5_err} !==
                {m_data[1], m_valid[1], 3'(m_sel[1]), m_wrap[1], m_err[1]}) begin
                failures++;
                $display("FAIL random_dut5 c=%0d got=%h exp=%h", c,
                         {o5_data, o5_valid, o5_sel, o5_wrap, o5_err},
                         {m_data[1], m_valid[1], 3'(m_sel[1]), m_wrap[1], m_err[1]});
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_manual_sweep();
        test_scan();
        test_en_pause();
        test_sel_err();
        test_mode_toggle();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
